// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Shares the single-ported data RAM between the core execute stage and a
// debug/loader master. The core owns the port by default with no added
// latency. A debug request is granted in an idle slot, immediately when the
// master asks for locked (bulk-load) access, or after MAX_WAIT contended
// cycles, in which case the core is stalled through o_core_hold.
//
// Parameters:
//   MAX_WAIT  longest run of contended cycles a debug request waits (1..255)
//   AW, DW    address / data width
//
// Ports:
//   clk, i_reset                      clock, synchronous active-high reset
//   i_core_req/we/addr/wdata          core load/store request
//   o_core_rdata                      RAM read data to the core (combinational)
//   o_core_hold                       stall request to hold_ctrl (combinational)
//   i_dbg_req/we/addr/wdata/lock      debug request, held until o_dbg_ack
//   o_dbg_ack                         one-cycle completion pulse
//   o_dbg_rdata                       registered debug read data
//   o_ram_we/r_addr/w_addr/w_data     RAM port
//   i_ram_r_data                      RAM combinational read data

module ram_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_core_req,
    input  logic          i_core_we,
    input  logic [AW-1:0] i_core_addr,
    input  logic [DW-1:0] i_core_wdata,
    output logic [DW-1:0] o_core_rdata,
    output logic          o_core_hold,
    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_wdata,
    input  logic          i_dbg_lock,
    output logic          o_dbg_ack,
    output logic [DW-1:0] o_dbg_rdata,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_r_addr,
    output logic [AW-1:0] o_ram_w_addr,
    output logic [DW-1:0] o_ram_w_data,
    input  logic [DW-1:0] i_ram_r_data
);

    typedef enum logic [1:0] {
        S_CORE,
        S_DBG,
        S_ACK
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       dbg_grant;

    // A waiting debug request is granted when the core leaves the slot free,
    // when its wait budget is used up, or when the master asks for locked access.
    assign dbg_grant = i_dbg_req & (~i_core_req | (wait_cnt == WAIT_LAST) | i_dbg_lock);

    // The core is stalled for the whole debug access, and through the ack
    // cycle as well while lock is held so a bulk load runs back to back.
    assign o_core_hold = (state == S_DBG) | ((state == S_ACK) & i_dbg_lock);

    assign o_core_rdata = i_ram_r_data;

    // RAM port mux. The debug master drives the port only in S_DBG; a held
    // core store is masked so the stalled pipeline can retry it. Reset forces
    // the port quiet, which also drops a debug write caught in flight.
    always_comb begin
        o_ram_we     = 1'b0;
        o_ram_r_addr = '0;
        o_ram_w_addr = '0;
        o_ram_w_data = '0;
        if (!i_reset) begin
            if (state == S_DBG) begin
                o_ram_we     = i_dbg_we;
                o_ram_r_addr = i_dbg_addr;
                o_ram_w_addr = i_dbg_addr;
                o_ram_w_data = i_dbg_wdata;
            end else begin
                o_ram_we     = i_core_req & i_core_we & ~o_core_hold;
                o_ram_r_addr = i_core_addr;
                o_ram_w_addr = i_core_addr;
                o_ram_w_data = i_core_wdata;
            end
        end
    end

    // Arbitration FSM with its registered outputs. wait_cnt counts contended
    // cycles and deliberately keeps its value if the master withdraws, so a
    // re-request does not restart the starvation budget; only a grant clears it.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= S_CORE;
            wait_cnt    <= '0;
            o_dbg_ack   <= 1'b0;
            o_dbg_rdata <= '0;
        end else begin
            case (state)
                S_CORE: begin
                    o_dbg_ack <= 1'b0;
                    if (dbg_grant) begin
                        state    <= S_DBG;
                        wait_cnt <= '0;
                    end else if (i_dbg_req & i_core_req & (wait_cnt != WAIT_LAST)) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DBG: begin
                    state     <= S_ACK;
                    o_dbg_ack <= 1'b1;
                    // Only reads update the returned data; a write leaves the
                    // last read result in place.
                    if (!i_dbg_we) begin
                        o_dbg_rdata <= i_ram_r_data;
                    end
                end
                S_ACK: begin
                    o_dbg_ack <= 1'b0;
                    if (i_dbg_lock & i_dbg_req) begin
                        state    <= S_DBG;
                        wait_cnt <= '0;
                    end else begin
                        state <= S_CORE;
                    end
                end
                default: begin
                    state     <= S_CORE;
                    o_dbg_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-ported data RAM between the core execute stage and a debug/loader master. The core normally owns the port with zero added latency. The debug master is serviced in idle slots, or forcibly after a bounded wait, by stalling the core through the hold controller. The block sits between the execute stage, data_ram and hold_ctrl.

## Interface
- `MAX_WAIT`, default 8: the maximum number of consecutive contended cycles a debug request may wait before it pre-empts the core. Legal range is 1..255.
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clk` input 1: clock. All state changes on the rising edge.
- `i_reset` input 1: synchronous, active-high reset.
- `i_core_req` input 1: the core presents a load or store this cycle.
- `i_core_we` input 1: core store enable.
- `i_core_addr` input AW: core address.
- `i_core_wdata` input DW: core store data.
- `o_core_rdata` output DW: RAM read data routed to the core. Combinational.
- `o_core_hold` output 1: stall request to hold_ctrl. The core's access this cycle is not performed.
- `i_dbg_req` input 1: debug access request. Held high until `o_dbg_ack`.
- `i_dbg_we` input 1: debug write enable.
- `i_dbg_addr` input AW: debug address.
- `i_dbg_wdata` input DW: debug write data.
- `i_dbg_lock` input 1: the debug master wants exclusive back-to-back access, for bulk program load.
- `o_dbg_ack` output 1: one-cycle completion pulse.
- `o_dbg_rdata` output DW: registered read data, valid while `o_dbg_ack` is high.
- `o_ram_we` output 1: RAM write enable.
- `o_ram_r_addr` output AW: RAM read address.
- `o_ram_w_addr` output AW: RAM write address.
- `o_ram_w_data` output DW: RAM write data.
- `i_ram_r_data` input DW: RAM read data. Combinational read; writes commit on the clock edge.

## Operation
**States**
- S_CORE: the core owns the port.
- S_DBG: one debug access is in progress.
- S_ACK: the debug acknowledge cycle.

**Port mux**
- In S_CORE and S_ACK, the RAM port is driven from the `i_core_*` inputs.
  - `o_ram_we` = `i_core_req & i_core_we & ~o_core_hold`.
- In S_DBG, the RAM port is driven from the `i_dbg_*` inputs.
  - `o_ram_we` = `i_dbg_we`.
- `o_core_rdata` = `i_ram_r_data` in every state.

**Hold**
- `o_core_hold` = (state == S_DBG) | (state == S_ACK & `i_dbg_lock`).
- `o_core_hold` is combinational.

**`wait_cnt`**
- 8-bit counter.
- Increments, saturating at `MAX_WAIT`−1, on every S_CORE cycle where `i_dbg_req & i_core_req` are both high.
- Clears on entry to S_DBG.

**Transitions**
- S_CORE → S_DBG when `i_dbg_req` is high and any of the following holds:
  - `~i_core_req`,
  - `wait_cnt == MAX_WAIT-1`,
  - `i_dbg_lock`.
- Otherwise the block stays in S_CORE.
- S_DBG → S_ACK unconditionally. On that edge, `o_dbg_rdata` ← `i_ram_r_data`, and a debug write commits.
- S_ACK → S_DBG when `i_dbg_lock & i_dbg_req`. Otherwise S_ACK → S_CORE.
- No new debug grant is issued in the ack cycle unless lock is set. This gives the master one cycle to change or drop its request.

**`o_dbg_ack`**
- Asserted exactly while in S_ACK.
- `o_dbg_rdata` holds its value until the next debug read completes.

**Reset values**
- State = S_CORE, `wait_cnt` = 0, `o_dbg_ack` = 0, `o_dbg_rdata` = 0.
- While `i_reset` is high, `o_ram_we` = 0 and all addresses and write data are 0.

## Timing
- Core access: 0 added latency when not held. A held core access is retried by the stalled pipeline and is never dropped.
- Debug access latency: 2 cycles (grant edge → S_DBG → ack) when the port is idle. The worst case under continuous core traffic is `MAX_WAIT`+1 cycles from request to ack.
- Lock mode throughput: one debug access per 2 cycles. `o_core_hold` stays high continuously until lock drops, which takes effect in the first S_ACK with lock low.
- Simultaneous `i_core_req` and `i_dbg_req` with `wait_cnt` < `MAX_WAIT`−1: the core wins and the counter increments.
- Debug request dropped while waiting in S_CORE: `wait_cnt` holds its value. It is not cleared until the next grant.
- Reset during S_DBG or S_ACK: the next state is S_CORE, no ack pulse is emitted, and a debug write in flight in S_DBG is not committed. The master must re-request.
- `MAX_WAIT` = 1: any contended debug request is granted on the next edge.

## Test plan
- **Idle debug read:** RAM[0x40]=0xDEADBEEF; `i_dbg_req`=1, addr 0x40, core idle → S_DBG next cycle, `o_dbg_ack`=1 two cycles after the request, `o_dbg_rdata`=0xDEADBEEF, `o_core_hold`=1 only in the S_DBG cycle.
- **Core priority and starvation bound:** `MAX_WAIT`=4, core stores every cycle to 0x100, plus a debug write of 0x12345678 to 0x200 → core writes for 4 contended cycles, then `o_core_hold`=1 for one cycle. `o_dbg_ack` arrives 5 cycles after the request; RAM[0x200]=0x12345678 and the core store completes on retry.
- **Lock burst:** `i_dbg_lock`=1 with 4 sequential writes to 0x0..0xC → 4 acks spaced 2 cycles apart, `o_core_hold` high for 8 consecutive cycles, and the core resumes the cycle after lock drops in S_ACK.
- **Held core store suppressed:** core store to 0x300 during S_DBG → `o_ram_we` follows `i_dbg_we` only, and RAM[0x300] is unchanged until the retry.
- **Reset mid-access:** assert `i_reset` in S_DBG with a debug write of 0xAAAA5555 to 0x10 → no ack, RAM[0x10] unchanged, and the next cycle shows S_CORE with `o_dbg_rdata`=0.
- **Ack spacing:** `i_dbg_req` is held high through S_ACK with lock=0 and core idle → S_ACK → S_CORE → S_DBG, so the second ack arrives 3 cycles after the first.
